// File: rtl/hex_rotate_ctrl.sv
// hex_rotate_ctrl: rotates four 2-bit glyph codes across HEX0..HEX3, advanced by a prescaled tick (RUN) or a step button (STOP).
module hex_rotate_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [9:0] LEDR
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  typedef enum logic {STOP, RUN} state_t;
  state_t state;
  logic [1:0] sw1, sw2, key1, key2, key_prev, rdy, offset;
  logic [CW-1:0] cnt;
  logic [3:0][1:0] chars;
  logic [3:0][6:0] hex;
  logic adv_led, run, dir, tick, step_p, load_p, advance;
  function automatic logic [6:0] seg(input logic [1:0] c);
    return c == 2'd0 ? 7'b0100001 : c == 2'd1 ? 7'b0000110 : c == 2'd2 ? 7'b1111001 : 7'b1111111;
  endfunction
  assign run = sw2[1];
  assign dir = sw2[0];
  assign step_p = key_prev[0] & ~key2[0];
  assign load_p = key_prev[1] & ~key2[1];
  assign tick = state == RUN && cnt == CW'(TICK_DIV - 1);
  assign advance = state == RUN ? tick : step_p;
  assign {HEX3, HEX2, HEX1, HEX0} = hex;
  assign LEDR = {6'b0, adv_led, state == RUN, offset};
  // key_prev stays low until the synchronizer holds real samples, so a key held through reset never looks like a press
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sw1 <= '0;
      sw2 <= '0;
      key1 <= '1;
      key2 <= '1;
      key_prev <= '0;
      rdy <= '0;
      state <= STOP;
      cnt <= '0;
      offset <= '0;
      chars <= '1;
      hex <= '1;
      adv_led <= 1'b0;
    end else begin
      sw1 <= SW[9:8];
      sw2 <= sw1;
      key1 <= KEY;
      key2 <= key1;
      rdy <= {rdy[0], 1'b1};
      key_prev <= key2 & {2{rdy[1]}};
      state <= run ? RUN : STOP;
      cnt <= (state == RUN && run && !tick) ? cnt + CW'(1) : '0;
      if (advance) offset <= dir ? offset - 2'd1 : offset + 2'd1;
      if (load_p) chars <= SW[7:0];
      adv_led <= advance;
      for (int k = 0; k < 4; k++) hex[k] <= seg(chars[2'(offset + 2'(k))]);
    end
  end
endmodule

// File: tb/tb_hex_rotate_ctrl.sv
// tb_hex_rotate_ctrl: directed vectors with hand-computed expectations for hex_rotate_ctrl at TICK_DIV = 4.
module tb_hex_rotate_ctrl;
  localparam logic [6:0] G_D = 7'b0100001, G_E = 7'b0000110, G_1 = 7'b1111001, G_B = 7'b1111111;
  logic clk = 1'b0, rst;
  logic [9:0] sw;
  logic [1:0] key;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [9:0] ledr;
  int n_cmp = 0, n_bad = 0;
  hex_rotate_ctrl #(.TICK_DIV(4)) dut (
    .CLOCK_50(clk), .RESET(rst), .SW(sw), .KEY(key),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .LEDR(ledr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input int k);
    key[k] = 1'b0;
    step(1);
    key[k] = 1'b1;
    step(2);
  endtask
  logic [1:0] exp_off [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [6:0] exp_h0 [4] = '{G_E, G_1, G_B, G_D};
  initial begin
    rst = 1'b1;
    key = 2'b11;
    sw = '0;
    step(2);
    chk("rst_hex", {hex3, hex2, hex1, hex0}, {4{G_B}});
    chk("rst_ledr", ledr, 10'h0);
    rst = 1'b0;
    step(3);
    sw = 10'b00_11100100;
    press(1);
    chk("load_off", ledr[1:0], 2'd0);
    step(1);
    chk("load_hex", {hex3, hex2, hex1, hex0}, {G_B, G_1, G_E, G_D});
    sw[9] = 1'b1;
    step(7);
    for (int i = 0; i < 4; i++) begin
      chk("run_off", ledr[1:0], exp_off[i]);
      chk("run_pulse", ledr[3:2], 2'b11);
      if (i == 3) sw[9:8] = 2'b01;
      step(1);
      chk("run_hex0", hex0, exp_h0[i]);
      chk("run_pulse_off", ledr[3], 1'b0);
      step(3);
    end
    chk("stop_state", ledr[2], 1'b0);
    chk("stop_off", ledr[1:0], 2'd0);
    press(0);
    chk("step_dn1", ledr[1:0], 2'd3);
    press(0);
    chk("step_dn2", ledr[1:0], 2'd2);
    key[0] = 1'b0;
    step(3);
    chk("step_dn3", ledr[1:0], 2'd1);
    step(20);
    chk("hold_off", ledr[1:0], 2'd1);
    key[0] = 1'b1;
    step(3);
    chk("release_off", ledr[1:0], 2'd1);
    sw[9:8] = 2'b10;
    step(4);
    key[0] = 1'b0;
    step(1);
    key[0] = 1'b1;
    step(2);
    chk("coinc_off", ledr[1:0], 2'd2);
    chk("coinc_pulse", ledr[3], 1'b1);
    step(1);
    chk("coinc_single", ledr[3:0], 4'b0110);
    sw[7:0] = 8'b00_01_10_11;
    key[1] = 1'b0;
    step(1);
    key[1] = 1'b1;
    step(2);
    chk("ldtick_off", ledr[1:0], 2'd3);
    step(1);
    chk("ldtick_hex", {hex3, hex2, hex1, hex0}, {G_E, G_1, G_B, G_D});
    key[0] = 1'b0;
    #2;
    rst = 1'b1;
    sw[9:8] = 2'b00;
    #1;
    chk("arst_hex", {hex3, hex2, hex1, hex0}, {4{G_B}});
    chk("arst_ledr", ledr, 10'h0);
    step(2);
    rst = 1'b0;
    step(10);
    chk("arst_hold_ledr", ledr, 10'h0);
    chk("arst_hold_hex0", hex0, G_B);
    key[0] = 1'b1;
    step(3);
    chk("arst_rel_ledr", ledr, 10'h0);
    press(0);
    chk("arst_press", ledr, 10'h009);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
